fsm_seq_ctrl: RTL

Programmable sequencer that drives and checks the two-state Moore `fsm` test block. It holds a transition/output table and an input-stimulus memory, and resets the `fsm` instance. It then walks a stimulus sequence one step per cycle, driving `cs`/`in`/`ns`/`exp_out` into the `fsm` and comparing the returned `out` against the table. It sits between the bench/host configuration port and the `fsm` instance and reports pass/fail plus the first failing step.

---
 rtl/fsm_seq_pkg.sv | 26 ++
 rtl/fsm_seq_table.sv | 37 +++
 rtl/fsm_seq_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg
// Shared types and default sizing for the fsm_seq_ctrl sequencer.
//   state_t : sequencer control states
//   row_t   : one transition/output table row {next0, next1, out}
//   *_DEF   : default state width, output width and stimulus depth
package fsm_seq_pkg;

  localparam int SW_DEF    = 1;
  localparam int OUT_W_DEF = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRST = 2'd1,
    STEP = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Row widths follow the package defaults; the top's SW/OUT_W must match them.
  typedef struct packed {
    logic [SW_DEF-1:0]    next0;
    logic [SW_DEF-1:0]    next1;
    logic [OUT_W_DEF-1:0] out;
  } row_t;

endpackage

// File: rtl/fsm_seq_table.sv
// fsm_seq_table
// Register-file transition/output table, one row per fsm state.
//   clk, reset : clock, synchronous active-high reset (clears every row)
//   we         : write strobe
//   wr_state   : row written
//   wr_row     : row contents {next0, next1, out}
//   rd_state   : row read (combinational)
//   rd_row     : contents of row rd_state
module fsm_seq_table
  import fsm_seq_pkg::*;
#(
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [SW-1:0] wr_state,
  input  row_t          wr_row,
  input  logic [SW-1:0] rd_state,
  output row_t          rd_row
);

  localparam int ROWS = 1 << SW;

  row_t rows [ROWS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
    end else if (we) begin
      rows[wr_state] <= wr_row;
    end
  end

  assign rd_row = rows[rd_state];

endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl
// Programmable sequencer that resets, drives and checks a two-state Moore fsm.
//   clk, reset          : clock, synchronous active-high reset
//   cfg_*               : table write port (accepted in IDLE only)
//   stim_*              : stimulus memory write port (accepted in IDLE only)
//   start, seq_len      : launch a run of seq_len steps (saturated to DEPTH)
//   dut_out             : fsm output, combinational from dut_cs
//   dut_reset/cs/ns/in/exp : drive to the fsm (zero outside STEP, except dut_reset in DRST)
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   pass, mismatch_cnt, first_err_idx, err_valid : results of the last run
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int SW    = SW_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [SW-1:0]              cfg_state,
  input  logic [SW-1:0]              cfg_next0,
  input  logic [SW-1:0]              cfg_next1,
  input  logic [OUT_W-1:0]           cfg_out,
  input  logic                       stim_we,
  input  logic [$clog2(DEPTH)-1:0]   stim_addr,
  input  logic                       stim_bit,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     seq_len,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       dut_reset,
  output logic [SW-1:0]              dut_cs,
  output logic [SW-1:0]              dut_ns,
  output logic                       dut_in,
  output logic [OUT_W-1:0]           dut_exp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH):0]     mismatch_cnt,
  output logic [$clog2(DEPTH)-1:0]   first_err_idx,
  output logic                       err_valid
);

  localparam int              IW      = $clog2(DEPTH);
  localparam logic [IW:0]     DEPTH_L = (IW+1)'(DEPTH);

  function automatic logic [IW:0] sat_len(input logic [IW:0] len_in);
    return (len_in > DEPTH_L) ? DEPTH_L : len_in;
  endfunction

  state_t            state, state_nxt;
  logic [IW:0]       len;
  logic [IW:0]       idx;
  logic [SW-1:0]     cur;
  logic [SW-1:0]     next_cs;
  logic [DEPTH-1:0]  stim;
  row_t              cur_row;
  row_t              wr_row;
  logic              step_in;
  logic              miss;
  logic              last_step;
  logic              table_we;

  assign table_we     = cfg_we && (state == IDLE);
  assign wr_row.next0 = cfg_next0;
  assign wr_row.next1 = cfg_next1;
  assign wr_row.out   = cfg_out;

  fsm_seq_table #(.SW(SW)) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (table_we),
    .wr_state (cfg_state),
    .wr_row   (wr_row),
    .rd_state (cur),
    .rd_row   (cur_row)
  );

  assign step_in   = stim[idx[IW-1:0]];
  assign last_step = (idx == len - 1'b1);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_comb begin
    state_nxt = state;
    dut_reset = 1'b0;
    dut_cs    = '0;
    dut_ns    = '0;
    dut_in    = 1'b0;
    dut_exp   = '0;
    next_cs   = step_in ? cur_row.next1 : cur_row.next0;
    miss      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = DRST;
      DRST: begin
        dut_reset = 1'b1;
        state_nxt = (len != '0) ? STEP : FIN;
      end
      STEP: begin
        dut_in  = step_in;
        dut_cs  = cur;
        dut_ns  = next_cs;
        dut_exp = cur_row.out;
        // dut_out follows dut_cs combinationally, so compare in this same cycle.
        miss    = (dut_out != cur_row.out);
        if (last_step) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      idx           <= '0;
      cur           <= '0;
      stim          <= '0;
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
      err_valid     <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (stim_we) stim[stim_addr] <= stim_bit;
          if (start) begin
            len           <= sat_len(seq_len);
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            err_valid     <= 1'b0;
            pass          <= 1'b0;
          end
        end
        DRST: begin
          cur <= '0;
          idx <= '0;
          if (len == '0) pass <= 1'b1;
        end
        STEP: begin
          cur <= next_cs;
          idx <= idx + 1'b1;
          if (miss) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!err_valid) begin
              first_err_idx <= idx[IW-1:0];
              err_valid     <= 1'b1;
            end
          end
          // pass is settled on entry to FIN so it is already valid alongside done.
          if (last_step) pass <= ~(err_valid | miss);
        end
        default: ;
      endcase
    end
  end

endmodule
